// File: rtl/fifo_read_prefetch_if.sv
// Bus bundle between the read-prefetch stage, the FIFO wrapper read port
// and the downstream valid/ready consumer.
interface fifo_read_prefetch_if #(
  parameter int W = 32
);
  logic         CLR;
  logic [W-1:0] F_DOUT;
  logic         F_EMPTY_N;
  logic         F_RDRSTBUSY;
  logic         F_RDEN;
  logic [W-1:0] M_DATA;
  logic         M_VALID;
  logic         M_READY;
  logic [2:0]   LEVEL;

  modport slave (
    input  CLR, F_DOUT, F_EMPTY_N, F_RDRSTBUSY, M_READY,
    output F_RDEN, M_DATA, M_VALID, LEVEL
  );

  modport master (
    output CLR, F_DOUT, F_EMPTY_N, F_RDRSTBUSY, M_READY,
    input  F_RDEN, M_DATA, M_VALID, LEVEL
  );
endinterface

// File: rtl/fifo_read_prefetch.sv
// Read-side prefetch stage for a non-FWFT FIFO: issues reads against buffer
// credit, tracks the primitive read latency and re-streams words as valid/ready.
module fifo_read_prefetch #(
  parameter int W          = 32,
  parameter int RD_LATENCY = 2,
  parameter int DEPTH      = RD_LATENCY + 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  fifo_read_prefetch_if.slave  bus
);

  localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  if (RD_LATENCY < 1 || RD_LATENCY > 3 || DEPTH < RD_LATENCY + 2 || DEPTH > 7) begin : g_bad_params
    $error("fifo_read_prefetch: illegal RD_LATENCY/DEPTH combination");
  end

  logic                  r_run;
  logic [RD_LATENCY-1:0] r_pipe;
  logic [W-1:0]          r_buf [DEPTH];
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [2:0]            r_count;

  logic [3:0] w_inflight;
  logic       w_rden;
  logic       w_write;
  logic       w_pop;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      w_inflight = w_inflight + 4'(r_pipe[i]);
    end
  end

  // Credit uses registered count only, so M_READY never reaches F_RDEN.
  assign w_rden  = r_run & bus.F_EMPTY_N & ~bus.F_RDRSTBUSY & ~bus.CLR &
                   (({1'b0, r_count} + w_inflight) < DEPTH_C);
  assign w_write = r_pipe[RD_LATENCY-1];
  assign w_pop   = (r_count != 3'd0) & bus.M_READY;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pipe <= '0;
    end else if (bus.CLR) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= w_rden;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_buf[i] <= '0;
      end
    end else if (!bus.CLR && w_write) begin
      r_buf[r_tail] <= bus.F_DOUT;
    end
  end

  // Flush wins over capture and pop; words still returning are dropped.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (bus.CLR) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_write) begin
        r_tail <= nextPtr(r_tail);
      end
      if (w_pop) begin
        r_head <= nextPtr(r_head);
      end
      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.F_RDEN  = w_rden;
  assign bus.M_VALID = (r_count != 3'd0);
  assign bus.M_DATA  = r_buf[r_head];
  assign bus.LEVEL   = r_count;

  a_no_overflow : assert property (@(posedge CLK) disable iff (RST)
    !(w_write && !bus.CLR && (r_count == DEPTH_C[2:0])));

endmodule

// File: tb/tb_fifo_read_prefetch.sv
// Self-checking bench: behavioural non-FWFT FIFO model feeding the stage,
// a streaming vector table and hand-written corner sequences.
module tb_fifo_read_prefetch;

  localparam int W     = 32;
  localparam int RDL   = 2;
  localparam int DEPTH = RDL + 2;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  fifo_read_prefetch_if #(.W(W)) bus ();

  fifo_read_prefetch #(.W(W), .RD_LATENCY(RDL), .DEPTH(DEPTH)) dut (
    .CLK (clock),
    .RST (reset),
    .bus (bus)
  );

  logic [W-1:0] stimWords [256];
  int           stimLen   = 0;
  int           nextIdx   = 0;
  logic [W-1:0] issued [$];
  int           expIdx    = 0;
  int           recvCount = 0;
  logic         stg1Valid = 1'b0;
  logic [W-1:0] stg1Data  = '0;
  int           vectors     = 0;
  int           miscompares = 0;

  typedef struct {
    logic         ready;
    logic         busy;
    logic         expRden;
    logic         expValid;
    logic [W-1:0] expData;
    logic [2:0]   expLevel;
  } vec_t;

  vec_t vecs [8];

  assign bus.F_EMPTY_N = (nextIdx < stimLen);

  // Wrapper model: a word read at edge E appears on F_DOUT two cycles after the RDEN cycle.
  always @(posedge clock) begin
    if (stg1Valid) bus.F_DOUT <= stg1Data;
    else           bus.F_DOUT <= $urandom;
    stg1Valid <= bus.F_RDEN;
    if (bus.F_RDEN) begin
      stg1Data <= stimWords[nextIdx];
      issued.push_back(stimWords[nextIdx]);
      nextIdx <= nextIdx + 1;
    end else if (bus.CLR) begin
      nextIdx <= stimLen;
    end
  end

  task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.M_READY     = v.ready;
    bus.F_RDRSTBUSY = v.busy;
    bus.CLR         = 1'b0;
  endtask

  task automatic pushWords(input int n, input logic [W-1:0] base);
    for (int i = 0; i < n; i++) begin
      stimWords[stimLen] = base + W'(i);
      stimLen++;
    end
  endtask

  // Mid-cycle sample: scoreboard compare on every accepted word, discard on flush/reset.
  task automatic sampleCycle();
    @(negedge clock);
    if (reset || bus.CLR) begin
      expIdx = issued.size();
    end else if (bus.M_VALID && bus.M_READY) begin
      if (expIdx < issued.size()) begin
        checkOutput("stream_data", bus.M_DATA, issued[expIdx]);
        expIdx++;
      end else begin
        checkOutput("spurious_valid", W'(bus.M_VALID), '0);
      end
      recvCount++;
    end
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic drainAll(input int bound);
    logic drained;
    drained = 1'b0;
    bus.M_READY = 1'b1;
    for (int k = 0; k < bound && !drained; k++) begin
      nextCycle();
      sampleCycle();
      drained = (nextIdx == stimLen) && (expIdx == issued.size()) &&
                !bus.M_VALID && (bus.LEVEL == 3'd0);
    end
    checkOutput("drain_done", W'(drained), W'(1));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int rdenCount;
    int base;

    reset           = 1'b1;
    bus.CLR         = 1'b0;
    bus.M_READY     = 1'b0;
    bus.F_RDRSTBUSY = 1'b0;
    stimWords[0] = 32'h11;
    stimWords[1] = 32'h22;
    stimWords[2] = 32'h33;
    stimLen      = 3;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 3'd0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h00, 3'd0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h00, 3'd0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h00, 3'd0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h11, 3'd1};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h22, 3'd1};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h33, 3'd1};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 3'd0};

    // Held in reset with data available.
    repeat (2) sampleCycle();
    checkOutput("rst_rden",  W'(bus.F_RDEN),  '0);
    checkOutput("rst_valid", W'(bus.M_VALID), '0);
    checkOutput("rst_level", W'(bus.LEVEL),   '0);
    checkOutput("rst_data",  bus.M_DATA,      '0);

    // Release, then stream three words through the vector table.
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) nextCycle();
      applyStimulus(vecs[i]);
      sampleCycle();
      checkOutput($sformatf("tbl%0d_rden", i),  W'(bus.F_RDEN),  W'(vecs[i].expRden));
      checkOutput($sformatf("tbl%0d_valid", i), W'(bus.M_VALID), W'(vecs[i].expValid));
      checkOutput($sformatf("tbl%0d_level", i), W'(bus.LEVEL),   W'(vecs[i].expLevel));
      if (vecs[i].expValid) checkOutput($sformatf("tbl%0d_data", i), bus.M_DATA, vecs[i].expData);
    end

    // Backpressure: credit limits reads to DEPTH, then a gapless drain.
    nextCycle();
    bus.M_READY = 1'b0;
    pushWords(10, 32'hB000_0000);
    rdenCount = 0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) nextCycle();
      sampleCycle();
      if (bus.F_RDEN) rdenCount++;
    end
    checkOutput("bp_rden_pulses", W'(rdenCount),   W'(DEPTH));
    checkOutput("bp_level",       W'(bus.LEVEL),   W'(DEPTH));
    checkOutput("bp_valid_held",  W'(bus.M_VALID), W'(1));
    checkOutput("bp_head_hold",   bus.M_DATA,      issued[expIdx]);
    nextCycle();
    bus.M_READY = 1'b1;
    base = recvCount;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) nextCycle();
      sampleCycle();
      checkOutput($sformatf("bp_run%0d_valid", c), W'(bus.M_VALID), W'(1));
    end
    nextCycle();
    sampleCycle();
    checkOutput("bp_valid_end", W'(bus.M_VALID),     '0);
    checkOutput("bp_recv",      W'(recvCount - base), W'(10));

    // Reset-busy blocks new reads; the word already issued still arrives.
    nextCycle();
    pushWords(3, 32'hC000_0000);
    sampleCycle();
    checkOutput("busy_pre_rden", W'(bus.F_RDEN), W'(1));
    nextCycle();
    bus.F_RDRSTBUSY = 1'b1;
    base = recvCount;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) nextCycle();
      sampleCycle();
      checkOutput($sformatf("busy%0d_rden", c), W'(bus.F_RDEN), '0);
    end
    checkOutput("busy_inflight_recv", W'(recvCount - base), W'(1));
    bus.F_RDRSTBUSY = 1'b0;
    drainAll(40);
    checkOutput("busy_total_recv", W'(recvCount - base), W'(3));

    // Flush with two words buffered and two in flight.
    nextCycle();
    bus.M_READY = 1'b0;
    pushWords(10, 32'hD000_0000);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) nextCycle();
      sampleCycle();
    end
    nextCycle();
    bus.CLR     = 1'b1;
    bus.M_READY = 1'b1;
    sampleCycle();
    checkOutput("flush_pre_level", W'(bus.LEVEL),  W'(2));
    checkOutput("flush_rden",      W'(bus.F_RDEN), '0);
    nextCycle();
    bus.CLR = 1'b0;
    base = recvCount;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) nextCycle();
      sampleCycle();
      checkOutput($sformatf("flush%0d_valid", c), W'(bus.M_VALID), '0);
      checkOutput($sformatf("flush%0d_level", c), W'(bus.LEVEL),   '0);
    end
    checkOutput("flush_no_words", W'(recvCount - base), '0);

    // Asynchronous reset in the middle of a stream.
    nextCycle();
    pushWords(12, 32'hE000_0000);
    for (int c = 0; c < 6; c++) begin
      if (c > 0) nextCycle();
      sampleCycle();
    end
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("arst_rden",  W'(bus.F_RDEN),  '0);
    checkOutput("arst_valid", W'(bus.M_VALID), '0);
    checkOutput("arst_level", W'(bus.LEVEL),   '0);
    sampleCycle();
    @(posedge clock);
    #3;
    reset = 1'b0;
    sampleCycle();
    checkOutput("arst_first_rden", W'(bus.F_RDEN), '0);
    nextCycle();
    sampleCycle();
    checkOutput("arst_second_rden", W'(bus.F_RDEN), W'(1));
    drainAll(60);
    checkOutput("arst_model_done", W'(nextIdx), W'(stimLen));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
